// File: rtl/axi_wdata_router.sv
// ---------------------------------------------------------------------------
// axi_wdata_router
//   AXI write-data crossbar. It forwards W beats from NUM_M masters to NUM_S
//   slaves. The AW arbiter pushes one route {mst, slv, len} for each granted
//   AW. Routes are served in grant order. The master named by the head route
//   streams its burst into a 2-entry skid buffer, and the skid buffer drives
//   the addressed slave port. The forwarded WLAST comes from the beat count.
//   Any disagreement with the master's WLAST sets a sticky error flag.
//
// Ports
//   ACLK, ARESETn             clock, asynchronous active-low reset
//   aw_push/aw_mst/aw_slv/    route push from the AW arbiter
//   aw_len
//   route_full                route FIFO full; the arbiter must hold off AW
//   WDATA_M/WSTRB_M/WLAST_M/  packed master W channels, master i in slice i
//   WVALID_M/WREADY_M
//   WDATA_S/WSTRB_S/WLAST_S/  packed slave W channels, slave j in slice j
//   WVALID_S/WREADY_S
//   wlast_err, err_clr        sticky WLAST mismatch flag and its clear
// ---------------------------------------------------------------------------
module axi_wdata_router #(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 5,
    parameter int DATA_W      = 32,
    parameter int ROUTE_DEPTH = 4,
    localparam int STRB_W     = DATA_W / 8,
    localparam int MW         = $clog2(NUM_M),
    localparam int SW         = $clog2(NUM_S)
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       aw_push,
    input  logic [MW-1:0]              aw_mst,
    input  logic [SW-1:0]              aw_slv,
    input  logic [7:0]                 aw_len,
    output logic                       route_full,
    input  logic [NUM_M*DATA_W-1:0]    WDATA_M,
    input  logic [NUM_M*STRB_W-1:0]    WSTRB_M,
    input  logic [NUM_M-1:0]           WLAST_M,
    input  logic [NUM_M-1:0]           WVALID_M,
    output logic [NUM_M-1:0]           WREADY_M,
    output logic [NUM_S*DATA_W-1:0]    WDATA_S,
    output logic [NUM_S*STRB_W-1:0]    WSTRB_S,
    output logic [NUM_S-1:0]           WLAST_S,
    output logic [NUM_S-1:0]           WVALID_S,
    input  logic [NUM_S-1:0]           WREADY_S,
    output logic                       wlast_err,
    input  logic                       err_clr
);

    localparam int PW = $clog2(ROUTE_DEPTH);
    localparam int CW = PW + 1;

    // route FIFO
    logic [MW-1:0] rt_mst_q [ROUTE_DEPTH];
    logic [SW-1:0] rt_slv_q [ROUTE_DEPTH];
    logic [7:0]    rt_len_q [ROUTE_DEPTH];
    logic [PW-1:0] rt_wr_q, rt_rd_q;
    logic [CW-1:0] rt_cnt_q, rt_cnt_d;

    // skid buffer
    logic [DATA_W-1:0] sk_data_q [2];
    logic [STRB_W-1:0] sk_strb_q [2];
    logic              sk_last_q [2];
    logic [SW-1:0]     sk_slv_q  [2];
    logic              sk_wr_q, sk_rd_q;
    logic [1:0]        sk_cnt_q, sk_cnt_d;

    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       err_q, err_d;

    logic          rt_empty, rt_push, rt_pop;
    logic          sk_full, sk_pop, acc, beat_last;
    logic [MW-1:0] head_mst;
    logic [SW-1:0] head_slv, out_slv;
    logic [7:0]    head_len;

    assign rt_empty   = (rt_cnt_q == '0);
    assign route_full = (rt_cnt_q == CW'(ROUTE_DEPTH));
    assign head_mst   = rt_mst_q[rt_rd_q];
    assign head_slv   = rt_slv_q[rt_rd_q];
    assign head_len   = rt_len_q[rt_rd_q];
    assign sk_full    = (sk_cnt_q == 2'd2);
    assign beat_last  = (beat_cnt_q == head_len);
    assign out_slv    = sk_slv_q[sk_rd_q];

    // A push while full is dropped even if the head pops this cycle.
    assign rt_push = aw_push && !route_full;
    assign acc     = !rt_empty && !sk_full && WVALID_M[head_mst];
    assign rt_pop  = acc && beat_last;
    assign sk_pop  = (sk_cnt_q != 2'd0) && WREADY_S[out_slv];

    always_comb begin
        WREADY_M = '0;
        if (!rt_empty && !sk_full) begin
            WREADY_M[head_mst] = 1'b1;
        end
    end

    // Only the addressed slave port sees the head entry; all others stay zero.
    always_comb begin
        WVALID_S = '0;
        WLAST_S  = '0;
        WDATA_S  = '0;
        WSTRB_S  = '0;
        if (sk_cnt_q != 2'd0) begin
            WVALID_S[out_slv]                     = 1'b1;
            WLAST_S[out_slv]                      = sk_last_q[sk_rd_q];
            WDATA_S[out_slv*DATA_W +: DATA_W]     = sk_data_q[sk_rd_q];
            WSTRB_S[out_slv*STRB_W +: STRB_W]     = sk_strb_q[sk_rd_q];
        end
    end

    always_comb begin
        rt_cnt_d = rt_cnt_q;
        case ({rt_push, rt_pop})
            2'b10:   rt_cnt_d = rt_cnt_q + CW'(1);
            2'b01:   rt_cnt_d = rt_cnt_q - CW'(1);
            default: rt_cnt_d = rt_cnt_q;
        endcase

        sk_cnt_d = sk_cnt_q;
        case ({acc, sk_pop})
            2'b10:   sk_cnt_d = sk_cnt_q + 2'd1;
            2'b01:   sk_cnt_d = sk_cnt_q - 2'd1;
            default: sk_cnt_d = sk_cnt_q;
        endcase

        beat_cnt_d = beat_cnt_q;
        if (acc) begin
            beat_cnt_d = beat_last ? 8'd0 : beat_cnt_q + 8'd1;
        end

        // set wins over clear
        err_d = err_q;
        if (acc && (WLAST_M[head_mst] != beat_last)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    assign wlast_err = err_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rt_wr_q    <= '0;
            rt_rd_q    <= '0;
            rt_cnt_q   <= '0;
            sk_wr_q    <= 1'b0;
            sk_rd_q    <= 1'b0;
            sk_cnt_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < ROUTE_DEPTH; i++) begin
                rt_mst_q[i] <= '0;
                rt_slv_q[i] <= '0;
                rt_len_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_strb_q[i] <= '0;
                sk_last_q[i] <= 1'b0;
                sk_slv_q[i]  <= '0;
            end
        end else begin
            rt_cnt_q   <= rt_cnt_d;
            sk_cnt_q   <= sk_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            if (rt_push) begin
                rt_mst_q[rt_wr_q] <= aw_mst;
                rt_slv_q[rt_wr_q] <= aw_slv;
                rt_len_q[rt_wr_q] <= aw_len;
                rt_wr_q           <= rt_wr_q + PW'(1);
            end
            if (rt_pop) begin
                rt_rd_q <= rt_rd_q + PW'(1);
            end
            if (acc) begin
                sk_data_q[sk_wr_q] <= WDATA_M[head_mst*DATA_W +: DATA_W];
                sk_strb_q[sk_wr_q] <= WSTRB_M[head_mst*STRB_W +: STRB_W];
                sk_last_q[sk_wr_q] <= beat_last;
                sk_slv_q[sk_wr_q]  <= head_slv;
                sk_wr_q            <= ~sk_wr_q;
            end
            if (sk_pop) begin
                sk_rd_q <= ~sk_rd_q;
            end
        end
    end

endmodule

// File: tb/tb_axi_wdata_router.sv
// ---------------------------------------------------------------------------
// tb_axi_wdata_router
//   Scoreboard bench. Beats accepted on the master side are pushed, with the
//   slave index and WLAST that a reference route model predicts. They are
//   popped and compared when a slave completes a handshake. Every cycle the
//   monitor also compares the slave outputs against the scoreboard head.
//   It compares WREADY_M against the route/skid occupancy, and it compares
//   route_full and wlast_err against the model.
// ---------------------------------------------------------------------------
module tb_axi_wdata_router;

    localparam int NUM_M  = 2;
    localparam int NUM_S  = 5;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int DEPTH  = 4;

    logic                    ACLK;
    logic                    ARESETn;
    logic                    aw_push;
    logic [0:0]              aw_mst;
    logic [2:0]              aw_slv;
    logic [7:0]              aw_len;
    logic                    route_full;
    logic [NUM_M*DATA_W-1:0] WDATA_M;
    logic [NUM_M*STRB_W-1:0] WSTRB_M;
    logic [NUM_M-1:0]        WLAST_M;
    logic [NUM_M-1:0]        WVALID_M;
    logic [NUM_M-1:0]        WREADY_M;
    logic [NUM_S*DATA_W-1:0] WDATA_S;
    logic [NUM_S*STRB_W-1:0] WSTRB_S;
    logic [NUM_S-1:0]        WLAST_S;
    logic [NUM_S-1:0]        WVALID_S;
    logic [NUM_S-1:0]        WREADY_S;
    logic                    wlast_err;
    logic                    err_clr;

    axi_wdata_router #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .DATA_W(DATA_W), .ROUTE_DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .aw_push(aw_push), .aw_mst(aw_mst), .aw_slv(aw_slv), .aw_len(aw_len),
        .route_full(route_full),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .wlast_err(wlast_err), .err_clr(err_clr)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        int          slv;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    typedef struct {
        int mst;
        int slv;
        int len;
    } route_t;

    beat_t  sb[$];
    route_t rq[$];
    int     bcnt;
    logic   err_m;
    int     acc_total;
    int     n_tests;
    int     n_fail;
    logic   rdy_mode;
    int     cyc;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave readiness: always ready, or a 1,0,0 repeating pattern.
    always @(posedge ACLK) begin
        #1;
        cyc++;
        if (rdy_mode) WREADY_S = ((cyc % 3) == 0) ? '1 : '0;
        else          WREADY_S = '1;
    end

    // Monitor / reference model. Inputs change at posedge+1. At the negedge
    // the handshakes for the coming posedge are known.
    always @(negedge ACLK) begin
        logic [159:0] ed;
        logic [19:0]  es;
        logic [4:0]   ev, el;
        logic [1:0]   er;
        int           s, h, pre_sb;
        logic         acc, lst;
        beat_t        nb;
        route_t       nr;
        if (!ARESETn) begin
            check_eq("rst_wvalid_s", WVALID_S, 0);
            check_eq("rst_wready_m", WREADY_M, 0);
            check_eq("rst_wdata_s", WDATA_S, 0);
            check_eq("rst_route_full", route_full, 0);
            check_eq("rst_wlast_err", wlast_err, 0);
            sb.delete();
            rq.delete();
            bcnt  = 0;
            err_m = 1'b0;
        end else begin
            pre_sb = sb.size();
            ed = '0; es = '0; ev = '0; el = '0;
            if (pre_sb != 0) begin
                s  = sb[0].slv;
                ev = 5'(1) << s;
                el = sb[0].last ? ev : 5'(0);
                ed = 160'(sb[0].data) << (s * 32);
                es = 20'(sb[0].strb) << (s * 4);
            end
            check_eq("wvalid_s", WVALID_S, ev);
            check_eq("wlast_s", WLAST_S, el);
            check_eq("wdata_s", WDATA_S, ed);
            check_eq("wstrb_s", WSTRB_S, es);
            check_eq("route_full", route_full, rq.size() == DEPTH);
            check_eq("wlast_err", wlast_err, err_m);

            acc = 1'b0;
            lst = 1'b0;
            if (rq.size() == 0) begin
                check_eq("wready_m_idle", WREADY_M, 0);
            end else begin
                h  = rq[0].mst;
                er = (pre_sb < 2) ? (2'(1) << h) : 2'(0);
                check_eq("wready_m", WREADY_M, er);
                acc = WVALID_M[h] && WREADY_M[h];
                lst = (bcnt == rq[0].len);
                if (acc) begin
                    nb.slv  = rq[0].slv;
                    nb.data = WDATA_M[h*32 +: 32];
                    nb.strb = WSTRB_M[h*4 +: 4];
                    nb.last = lst;
                end
            end

            // mutate model for the coming edge
            if (pre_sb != 0 && WREADY_S[sb[0].slv]) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(nb);
                acc_total++;
                if (WLAST_M[rq[0].mst] != lst) err_m = 1'b1;
                else if (err_clr) err_m = 1'b0;
                if (lst) begin
                    bcnt = 0;
                end else begin
                    bcnt++;
                end
            end else if (err_clr) begin
                err_m = 1'b0;
            end
            if (aw_push && rq.size() < DEPTH) begin
                nr.mst = int'(aw_mst);
                nr.slv = int'(aw_slv);
                nr.len = int'(aw_len);
                if (acc && lst) void'(rq.pop_front());
                rq.push_back(nr);
            end else if (acc && lst) begin
                void'(rq.pop_front());
            end
        end
    end

    task automatic aw(input int m, input int s, input int len);
        aw_push = 1'b1;
        aw_mst  = 1'(m);
        aw_slv  = 3'(s);
        aw_len  = 8'(len);
        @(posedge ACLK); #1;
        aw_push = 1'b0;
    endtask

    task automatic send_burst(input int m, input int n, input int base, input int last_at);
        logic done;
        int   t;
        for (int i = 0; i < n; i++) begin
            WVALID_M[m]         = 1'b1;
            WDATA_M[m*32 +: 32] = 32'(base + i);
            WSTRB_M[m*4 +: 4]   = 4'(i) ^ 4'hA;
            WLAST_M[m]          = (i == last_at);
            done = 1'b0;
            t    = 0;
            while (!done) begin
                @(negedge ACLK);
                done = WREADY_M[m];
                @(posedge ACLK); #1;
                if (!ARESETn) begin
                    WVALID_M[m] = 1'b0;
                    WLAST_M[m]  = 1'b0;
                    return;
                end
                t++;
                if (!done && t > 300) begin
                    check_eq("burst_timeout", 1, 0);
                    done = 1'b1;
                end
            end
        end
        WVALID_M[m] = 1'b0;
        WLAST_M[m]  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || rq.size() != 0) && t < 300) begin
            @(posedge ACLK); #1;
            t++;
        end
        check_eq(tag, sb.size() + rq.size(), 0);
    endtask

    initial begin
        int t, a0;
        n_tests = 0; n_fail = 0; acc_total = 0; cyc = 0; bcnt = 0;
        err_m = 1'b0; rdy_mode = 1'b0;
        ARESETn = 1'b0;
        aw_push = 1'b0; aw_mst = '0; aw_slv = '0; aw_len = '0;
        WDATA_M = '0; WSTRB_M = '0; WLAST_M = '0; WVALID_M = '0;
        WREADY_S = '1; err_clr = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // 1: single 4-beat burst m1 -> s3
        aw(1, 3, 3);
        send_burst(1, 4, 'hA0, 3);
        wait_idle("t1_drain");
        @(negedge ACLK);
        check_eq("t1_err", wlast_err, 0);
        @(posedge ACLK); #1;

        // 2: three routes, both masters contending
        aw(0, 1, 0);
        aw(1, 2, 1);
        aw(0, 4, 0);
        fork
            begin
                send_burst(0, 1, 'hB0, 0);
                send_burst(0, 1, 'hB2, 0);
            end
            send_burst(1, 2, 'hC0, 1);
        join
        wait_idle("t2_drain");

        // 3: fill the route FIFO; the 5th push must be dropped
        aw(0, 0, 0);
        aw(0, 1, 0);
        aw(0, 2, 0);
        aw(0, 3, 0);
        aw(1, 4, 0);
        @(negedge ACLK);
        check_eq("t3_full", route_full, 1);
        @(posedge ACLK); #1;
        send_burst(0, 1, 'h30, 0);
        @(negedge ACLK);
        check_eq("t3_not_full", route_full, 0);
        @(posedge ACLK); #1;
        for (int i = 1; i < 4; i++) send_burst(0, 1, 'h30 + i, 0);
        wait_idle("t3_drain");
        WVALID_M[1] = 1'b1;
        repeat (4) @(posedge ACLK);
        #1 WVALID_M[1] = 1'b0;

        // 4: early WLAST -> sticky error, corrected WLAST, then clear
        aw(0, 2, 2);
        send_burst(0, 3, 'hD0, 1);
        wait_idle("t4_drain");
        @(negedge ACLK);
        check_eq("t4_err_set", wlast_err, 1);
        @(posedge ACLK); #1 err_clr = 1'b1;
        @(posedge ACLK); #1 err_clr = 1'b0;
        @(negedge ACLK);
        check_eq("t4_err_clr", wlast_err, 0);
        @(posedge ACLK); #1;

        // 5: 8-beat burst into a stalling slave
        rdy_mode = 1'b1;
        aw(0, 1, 7);
        send_burst(0, 8, 'hE0, 7);
        wait_idle("t5_drain");
        rdy_mode = 1'b0;
        @(posedge ACLK); #1;

        // 6: reset in the middle of a burst, then a clean burst
        aw(1, 2, 3);
        a0 = acc_total;
        fork
            send_burst(1, 4, 'hF0, 3);
        join_none
        t = 0;
        while (acc_total < a0 + 2 && t < 100) begin
            @(negedge ACLK);
            t++;
        end
        check_eq("t6_two_beats", acc_total - a0 >= 2, 1);
        @(posedge ACLK); #2 ARESETn = 1'b0;
        #1;
        check_eq("t6_rst_wvalid_s", WVALID_S, 0);
        check_eq("t6_rst_wready_m", WREADY_M, 0);
        check_eq("t6_rst_wlast_s", WLAST_S, 0);
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        WVALID_M = '0;
        WLAST_M  = '0;
        @(posedge ACLK); #1;
        aw(0, 3, 1);
        send_burst(0, 2, 'h50, 1);
        wait_idle("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
